// File: rtl/multicore_datamemory_if.sv
// Bus bundle for multicore_datamemory: loader stream plus packed per-core access ports.
// master drives requests and loader words; slave is the memory block.
interface multicore_datamemory_if #(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 12,
   parameter int BUS_W  = 18,
   parameter int CORES  = 4
);
   logic                      load_valid;
   logic                      load_last;
   logic [BUS_W-1:0]          load_data;
   logic                      load_ready;
   logic                      load_done;
   logic [CORES-1:0]          req;
   logic [CORES-1:0]          we;
   logic [CORES*ADDR_W-1:0]   addr;
   logic [CORES*BUS_W-1:0]    wdata;
   logic [CORES-1:0]          gnt;
   logic [CORES-1:0]          rvalid;
   logic [DATA_W-1:0]         rdata;

   modport master (
      output load_valid, load_last, load_data, req, we, addr, wdata,
      input  load_ready, load_done, gnt, rvalid, rdata
   );

   modport slave (
      input  load_valid, load_last, load_data, req, we, addr, wdata,
      output load_ready, load_done, gnt, rvalid, rdata
   );
endinterface

// File: rtl/multicore_datamemory.sv
// Shared data memory for several cores with round-robin single-port access.
// Define DM_LOAD_PORT_EN to enable the boot LOAD state and loader port; otherwise it resets into RUN.
//
// state | meaning
// LOAD  | loader stream fills memory from address 0; core requests wait ungranted
// RUN   | cores arbitrated round-robin; loader inputs ignored
module multicore_datamemory #(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 12,
   parameter int BUS_W  = 18,
   parameter int CORES  = 4
) (
   input logic                   clk,
   input logic                   rst,
   multicore_datamemory_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;
   localparam int PTR_W = (CORES > 1) ? $clog2(CORES) : 1;

   typedef enum logic {LOAD, RUN} state_t;
`ifdef DM_LOAD_PORT_EN
   localparam state_t RESET_STATE = LOAD;
`else
   localparam state_t RESET_STATE = RUN;
`endif

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] load_ptr;
   logic [PTR_W-1:0]  rr_ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic [CORES-1:0]  rvalid_q;

   logic              load_acc;
   logic              load_end;
   logic [CORES-1:0]  gnt;
   logic              gnt_any;
   logic [PTR_W-1:0]  gnt_idx;
   int                arb_idx;
   logic              gnt_we;
   logic [ADDR_W-1:0] gnt_addr;
   logic [DATA_W-1:0] gnt_wdata;
   logic              unused_bits;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= RESET_STATE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      load_acc = 1'b0;
      load_end = 1'b0;
`ifdef DM_LOAD_PORT_EN
      if (state_q == LOAD && bus.load_valid) begin
         load_acc = 1'b1;
         load_end = bus.load_last || (&load_ptr);
         if (load_end) state_d = RUN;
      end
`else
      state_d = RUN;
`endif
   end

   // First requester at or after rr_ptr, wrapping modulo CORES.
   always_comb begin
      gnt     = '0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      arb_idx = 0;
      if (state_q == RUN) begin
         for (int k = 0; k < CORES; k++) begin
            arb_idx = (int'(rr_ptr) + k) % CORES;
            if (!gnt_any && bus.req[arb_idx]) begin
               gnt_any      = 1'b1;
               gnt_idx      = PTR_W'(arb_idx);
               gnt[arb_idx] = 1'b1;
            end
         end
      end
   end

   assign gnt_we    = bus.we[gnt_idx];
   assign gnt_addr  = bus.addr[gnt_idx*ADDR_W +: ADDR_W];
   assign gnt_wdata = bus.wdata[gnt_idx*BUS_W +: DATA_W];

   // Contents survive reset; writes are suppressed while reset is held.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (load_acc)
            mem[load_ptr] <= bus.load_data[DATA_W-1:0];
         else if (gnt_any && gnt_we)
            mem[gnt_addr] <= gnt_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_ptr <= '0;
         rr_ptr   <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
      end else begin
         if (load_acc)
            load_ptr <= load_end ? '0 : load_ptr + 1'b1;
         if (gnt_any)
            rr_ptr <= (gnt_idx == PTR_W'(CORES-1)) ? '0 : gnt_idx + 1'b1;
         rvalid_q <= (gnt_any && !gnt_we) ? gnt : '0;
         if (gnt_any && !gnt_we)
            rdata_q <= mem[gnt_addr];
      end
   end

   assign bus.load_ready = (state_q == LOAD);
   assign bus.load_done  = (state_q == RUN);
   assign bus.gnt        = gnt;
   assign bus.rvalid     = rvalid_q;
   assign bus.rdata      = rdata_q;

   // Upper bus bits are never stored; loader inputs are dead without the load port.
   assign unused_bits = ^{bus.load_valid, bus.load_last, bus.load_data, bus.wdata};
endmodule

// File: tb/tb_multicore_datamemory.sv
// Directed bench for multicore_datamemory: table of per-cycle access vectors plus load/reset sequences.
// The loader sequences are exercised when DM_LOAD_PORT_EN is defined for the build.
`timescale 1ns/1ps
module tb_multicore_datamemory;
   localparam int DATA_W = 12;
   localparam int ADDR_W = 12;
   localparam int BUS_W  = 18;
   localparam int CORES  = 4;

   typedef struct {
      logic [3:0]       req;
      logic [3:0]       we;
      logic [3:0][11:0] addr;
      logic [3:0][17:0] wdata;
      logic [3:0]       gnt;
      logic [3:0]       rvalid;
      logic             chk;
      logic [11:0]      rdata;
   } vec_t;

   localparam logic [3:0][11:0] RR_ADDR  = {12'd13, 12'd12, 12'd11, 12'd10};
   localparam logic [3:0][17:0] RR_WDATA = {18'h3F444, 18'h3F333, 18'h3F222, 18'h3F111};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   vec_t tbl [21];

   always #5 clk = ~clk;

   multicore_datamemory_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BUS_W(BUS_W), .CORES(CORES)) bus ();

   multicore_datamemory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BUS_W(BUS_W), .CORES(CORES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic vec_t mk(input logic [3:0] req, input logic [3:0] we,
                               input logic [3:0][11:0] addr, input logic [3:0][17:0] wdata,
                               input logic [3:0] gnt, input logic [3:0] rvalid,
                               input logic chk, input logic [11:0] rdata);
      vec_t v;
      v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
      v.gnt = gnt; v.rvalid = rvalid; v.chk = chk; v.rdata = rdata;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string name);
      @(negedge clk);
      bus.req = v.req; bus.we = v.we; bus.addr = v.addr; bus.wdata = v.wdata;
      #1;
      check({name, " gnt"}, 32'(bus.gnt), 32'(v.gnt));
      @(posedge clk); #1;
      check({name, " rvalid"}, 32'(bus.rvalid), 32'(v.rvalid));
      if (v.chk) check({name, " rdata"}, 32'(bus.rdata), 32'(v.rdata));
   endtask

   task automatic load_word(input logic [17:0] d, input logic last, input logic chk_ready, input logic chk_gnt);
      @(negedge clk);
      bus.load_valid = 1'b1; bus.load_data = d; bus.load_last = last;
      #1;
      if (chk_ready) begin
         check("load_ready while loading", 32'(bus.load_ready), 32'd1);
         check("load_done while loading", 32'(bus.load_done), 32'd0);
      end
      if (chk_gnt) check("gnt held off in LOAD", 32'(bus.gnt), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic load_stop;
      @(negedge clk);
      bus.load_valid = 1'b0; bus.load_last = 1'b0;
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1;
      bus.req = '0; bus.we = '0; bus.load_valid = 1'b0; bus.load_last = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bus.load_valid = 1'b0; bus.load_last = 1'b0; bus.load_data = '0;
      bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;

      tbl[0] = mk(4'b1111, 4'b1111, RR_ADDR, RR_WDATA, 4'b0001, 4'b0000, 1'b0, 12'd0);
      tbl[1] = mk(4'b1110, 4'b1110, RR_ADDR, RR_WDATA, 4'b0010, 4'b0000, 1'b0, 12'd0);
      tbl[2] = mk(4'b1100, 4'b1100, RR_ADDR, RR_WDATA, 4'b0100, 4'b0000, 1'b0, 12'd0);
      tbl[3] = mk(4'b1000, 4'b1000, RR_ADDR, RR_WDATA, 4'b1000, 4'b0000, 1'b0, 12'd0);
      for (int i = 4; i < 12; i++)
         tbl[i] = mk(4'b1111, 4'b0000, RR_ADDR, '0, 4'(1 << (i % 4)), 4'(1 << (i % 4)),
                     1'b1, 12'(12'h111 * ((i % 4) + 1)));
      tbl[12] = mk(4'b0100, 4'b0100, {12'd0, 12'd100, 24'd0}, {18'd0, 18'h3FABC, 36'd0},
                   4'b0100, 4'b0000, 1'b0, 12'd0);
      tbl[13] = mk(4'b0010, 4'b0000, {24'd0, 12'd100, 12'd0}, '0, 4'b0010, 4'b0010, 1'b1, 12'hABC);
      tbl[14] = mk(4'b0000, 4'b0000, '0, '0, 4'b0000, 4'b0000, 1'b1, 12'hABC);
      tbl[15] = mk(4'b1011, 4'b0000, RR_ADDR, '0, 4'b1000, 4'b1000, 1'b1, 12'h444);
      tbl[16] = mk(4'b0011, 4'b0000, RR_ADDR, '0, 4'b0001, 4'b0001, 1'b1, 12'h111);
      tbl[17] = mk(4'b0011, 4'b0010, {24'd0, 12'd10, 12'd10}, {36'd0, 18'h00555, 18'd0},
                   4'b0010, 4'b0000, 1'b0, 12'd0);
      tbl[18] = mk(4'b0001, 4'b0000, {24'd0, 12'd10, 12'd10}, '0, 4'b0001, 4'b0001, 1'b1, 12'h555);
      tbl[19] = mk(4'b1000, 4'b1000, {12'd4095, 36'd0}, {18'h2A7FF, 54'd0}, 4'b1000, 4'b0000, 1'b0, 12'd0);
      tbl[20] = mk(4'b1000, 4'b0000, {12'd4095, 36'd0}, '0, 4'b1000, 4'b1000, 1'b1, 12'h7FF);

      repeat (2) @(negedge clk);
`ifdef DM_LOAD_PORT_EN
      check("reset load_ready", 32'(bus.load_ready), 32'd1);
      check("reset load_done", 32'(bus.load_done), 32'd0);
`else
      check("reset load_ready", 32'(bus.load_ready), 32'd0);
      check("reset load_done", 32'(bus.load_done), 32'd1);
`endif
      check("reset rvalid", 32'(bus.rvalid), 32'd0);
      check("reset rdata", 32'(bus.rdata), 32'd0);
      rst = 1'b0;

`ifdef DM_LOAD_PORT_EN
      // Core 0 requests addr 31 throughout the load; it must wait, then be served.
      bus.req = 4'b0001; bus.we = 4'b0000; bus.addr = {36'd0, 12'd31};
      for (int w = 1; w <= 32; w++)
         load_word(18'(w), w == 32, 1'b0, (w == 1 || w == 32));
      check("load_done after last word", 32'(bus.load_done), 32'd1);
      check("load_ready after last word", 32'(bus.load_ready), 32'd0);
      check("held req granted in RUN", 32'(bus.gnt), 32'b0001);
      load_stop;
      @(posedge clk); #1;
      check("read addr31 rvalid", 32'(bus.rvalid), 32'b0001);
      check("read addr31 rdata", 32'(bus.rdata), 32'd32);
      @(negedge clk); bus.req = '0;
      @(posedge clk); #1;
      check("rvalid single cycle", 32'(bus.rvalid), 32'd0);

      do_reset;
      for (int i = 0; i < 10; i++) load_word(18'(100 + i), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      bus.load_valid = 1'b0; rst = 1'b1;
      #1 check("load_ready in mid-load reset", 32'(bus.load_ready), 32'd1);
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 5; i++) load_word(18'd7, i == 4, 1'b1, 1'b0);
      load_stop;
      for (int k = 0; k < 10; k++)
         apply(mk(4'b0001, 4'b0000, {36'd0, 12'(k)}, '0, 4'b0001, 4'b0001, 1'b1,
                  (k < 5) ? 12'd7 : 12'(100 + k)), $sformatf("reload addr%0d", k));

      do_reset;
      for (int n = 1; n <= 4096; n++) load_word(18'(n), 1'b0, n == 4096, 1'b0);
      check("load_done after 4096 words", 32'(bus.load_done), 32'd1);
      check("load_ptr wrapped", 32'(dut.load_ptr), 32'd0);
      load_stop;
`endif

      for (int i = 0; i < 21; i++) apply(tbl[i], $sformatf("vec%0d", i));

      apply(mk(4'b0001, 4'b0001, '0, {54'd0, 18'h00123}, 4'b0001, 4'b0000, 1'b0, 12'd0), "write addr0");
      @(negedge clk);
      bus.req = '0; bus.we = '0;
      bus.load_valid = 1'b1; bus.load_data = 18'h00999; bus.load_last = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("load_ready in RUN", 32'(bus.load_ready), 32'd0);
      check("load_done in RUN", 32'(bus.load_done), 32'd1);
      load_stop;
      apply(mk(4'b0001, 4'b0000, '0, '0, 4'b0001, 4'b0001, 1'b1, 12'h123), "loader ignored in RUN");

      // Reset lands on the edge that would have registered a granted read.
      @(negedge clk);
      bus.req = 4'b0100; bus.we = '0; bus.addr = {12'd0, 12'd100, 24'd0};
      #1 check("grant before reset", 32'(bus.gnt), 32'b0100);
      #2 rst = 1'b1;
      @(posedge clk); #1;
      check("in-flight read rvalid", 32'(bus.rvalid), 32'd0);
      check("in-flight read rdata", 32'(bus.rdata), 32'd0);
      @(negedge clk);
      bus.req = '0; rst = 1'b0;
`ifndef DM_LOAD_PORT_EN
      apply(mk(4'b0010, 4'b0000, {24'd0, 12'd100, 12'd0}, '0, 4'b0010, 4'b0010, 1'b1, 12'hABC),
            "mem kept over reset");
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/multicore_datamemory.md
MULTICORE_DATAMEMORY -- requirements
Module: multicore_datamemory

Interface
REQ-001 Parameter DATA_W, default 12, SHALL set the stored word width.
REQ-002 Parameter ADDR_W, default 12, SHALL set the address width; depth SHALL be 2**ADDR_W words.
REQ-003 Parameter BUS_W, default 18, SHALL set the bus-side input data width; only bits [DATA_W-1:0] SHALL be stored.
REQ-004 Parameter CORES, default 4, range 1-16, SHALL set the number of core ports.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 load_valid  in  1  loader word present.
REQ-008 load_last  in  1  qualifies the final loader word.
REQ-009 load_data  in  BUS_W  loader word.
REQ-010 load_ready  out  1  high while the block accepts loader words.
REQ-011 load_done  out  1  high once the block is in RUN.
REQ-012 req  in  CORES  per-core access request, level held until granted.
REQ-013 we  in  CORES  per-core write enable (1 = write, 0 = read).
REQ-014 addr  in  CORES*ADDR_W  packed per-core addresses, core i at [i*ADDR_W +: ADDR_W].
REQ-015 wdata  in  CORES*BUS_W  packed per-core write data.
REQ-016 gnt  out  CORES  one-hot grant, at most one bit high per cycle.
REQ-017 rvalid  out  CORES  one-hot read-data valid.
REQ-018 rdata  out  DATA_W  shared registered read data.

Function
REQ-019 The FSM SHALL have two states, LOAD and RUN.
REQ-020 In LOAD, load_ready SHALL be 1; each cycle with load_valid=1 SHALL write load_data[DATA_W-1:0] to mem[load_ptr] and increment load_ptr.
REQ-021 An accepted word with load_last=1, or an accepted word at load_ptr=2**ADDR_W-1, SHALL move the FSM to RUN on that edge; load_ptr SHALL wrap to 0.
REQ-022 In RUN, load_ready SHALL be 0; load_valid SHALL be ignored; load_done SHALL be 1.
REQ-023 In LOAD, gnt SHALL be all 0 and req SHALL be ignored, without being dropped.
REQ-024 In RUN, gnt SHALL be combinational: the first requesting core at or after rr_ptr, searching upward modulo CORES.
REQ-025 On a granted edge, rr_ptr SHALL become (granted index + 1) mod CORES; it SHALL hold when no core is granted.
REQ-026 A granted write SHALL update mem[addr_i] with wdata_i[DATA_W-1:0] on the grant edge; rvalid SHALL stay 0.
REQ-027 A granted read SHALL drive rdata=mem[addr_i] and rvalid[i]=1 exactly one cycle after the grant; rvalid SHALL be 1 for one cycle only.
REQ-028 A read granted in the cycle after a write to the same address SHALL return the new data.
REQ-029 rdata SHALL hold its last value while no rvalid bit is high.

Reset
REQ-030 rst=1 SHALL immediately force: state=LOAD (RUN when the macro is absent), load_ptr=0, rr_ptr=0, rvalid=0, rdata=0, load_done per state.
REQ-031 Memory contents SHALL NOT be cleared by reset.
REQ-032 Reset mid-load SHALL restart loading at address 0; a read in flight SHALL be discarded, with no rvalid.

Configuration
REQ-033 With macro DM_LOAD_PORT_EN defined, the LOAD state and loader port SHALL behave per REQ-020..REQ-023.
REQ-034 Without DM_LOAD_PORT_EN, the FSM SHALL reset into RUN and stay there; load_ready SHALL be 0 and load_done SHALL be 1; loader inputs SHALL be unused; port list SHALL be unchanged.

Verification
REQ-035 Defaults, macro defined. Stream 32 words 1..32 with load_last on word 32 -> load_done=1 on the following cycle. Core 0 then reads addr 31 -> rvalid[0]=1 and rdata=32 one cycle after gnt[0].
REQ-036 Stream 4096 words without load_last -> RUN is entered after word 4096 and load_ptr=0.
REQ-037 In RUN, req=4'b1111, all reads, held for 8 cycles -> gnt sequence 0,1,2,3,0,1,2,3.
REQ-038 Core 2 writes 0xABC to addr 100 (wdata=18'h3FABC) in one cycle; core 1 reads addr 100 in the next cycle -> rdata=0xABC.
REQ-039 Assert rst after 10 loaded words, then stream 5 words 7 -> mem[0..4]=7, mem[5..9] retain the first stream's values, load_ready=1 throughout.
REQ-040 Macro undefined: after reset, load_done=1 and load_ready=0; core 3 reads -> rvalid[3] occurs one cycle after gnt[3]; load_valid pulses do not change memory.
